mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM (4K x 32, registered read data, 1-cycle read latency) between the pipeline's instruction-fetch port and data (MEM-stage) port.
- Lets the processor run from one unified memory instead of separate imem/dmem instances.
- Gives fixed priority to the data port, with a starvation guard that forces an instruction grant after a bounded wait.
- Produces a stall signal that the IF stage uses to freeze r_pc and IfId registers.

Parameters:
ADDR_W, 12, word-address width (4096 words)
DATA_W, 32, data width
STARVE_MAX, 3, consecutive denied instruction-request cycles before the instruction port is forced to win; legal range 1..15

Ports:
w_clk  in  1  clock
w_rst  in  1  synchronous reset, active-high
w_ireq  in  1  instruction-fetch read request
w_iaddr  in  ADDR_W  instruction word address
w_igrant  out  1  instruction request accepted this cycle (combinational)
w_istall  out  1  w_ireq & ~w_igrant (combinational)
r_ivalid  out  1  w_irdata valid this cycle
w_irdata  out  DATA_W  instruction read data (= w_mdout)
w_dreq  in  1  data request
w_dwe  in  1  data write enable (1 = store, 0 = load)
w_daddr  in  ADDR_W  data word address
w_dwdata  in  DATA_W  store data
w_dgrant  out  1  data request accepted this cycle (combinational)
r_dvalid  out  1  w_drdata valid this cycle (loads only)
w_drdata  out  DATA_W  load data (= w_mdout)
w_maddr  out  ADDR_W  RAM address (combinational)
w_mwe  out  1  RAM write enable (combinational)
w_mdin  out  DATA_W  RAM write data (= w_dwdata)
w_mdout  in  DATA_W  RAM registered read data
r_conflicts  out  32  cycles with both requests asserted (optional feature)
r_forced  out  32  starvation-forced instruction grants (optional feature)

Behaviour:
- Reset (w_rst=1 at posedge):
  - r_ivalid=0, r_dvalid=0, starvation counter=0, r_conflicts=0, r_forced=0.
  - While w_rst=1, both grants are forced to 0 and w_mwe=0.
- Arbitration (combinational, each cycle):
  - Only one request asserted: that requester is granted.
  - Both asserted and counter < STARVE_MAX: data port is granted.
  - Both asserted and counter == STARVE_MAX: instruction port is granted (forced grant).
  - Neither asserted: no grant, w_maddr=0, w_mwe=0.
- RAM drive:
  - w_maddr is the granted requester's address.
  - w_mwe = w_dgrant & w_dwe.
  - The instruction port never writes.
- Read return:
  - r_ivalid <= w_igrant.
  - r_dvalid <= w_dgrant & ~w_dwe.
  - Data arrives on w_mdout exactly 1 cycle after the grant. Stores produce no valid pulse.
- Starvation counter (4-bit):
  - Increments when w_ireq & ~w_igrant, saturating at STARVE_MAX.
  - Clears to 0 when w_igrant=1 or w_ireq=0.
- Requester rule: req/addr/wdata are held stable until granted. Dropping req before grant is legal and clears the counter (instruction side).
- Stall rule: w_istall=1 means the IF stage holds r_pc and IfId registers. No data-side stall signal exists; the data port always wins unless a forced instruction grant occurs, and the MEM stage holds its request on ~w_dgrant.
- Read-after-write, same address, back-to-back grants: a read granted the cycle after a write returns the new data (RAM write completes at the grant posedge).
- Reset mid-transaction: any pending valid pulse is cancelled (r_ivalid/r_dvalid=0 the next cycle); an outstanding read is discarded.

Optional Feature:
MEM_ARB_STATS_EN
- Defined:
  - r_conflicts increments (wraps at 2^32) every cycle with w_ireq & w_dreq & ~w_rst.
  - r_forced increments on every forced instruction grant.
- Undefined: r_conflicts and r_forced are constant 0 and no counter logic is built. Arbitration behaviour is identical either way.

Test Plan:
1. Reset, then w_ireq=1, w_iaddr=5, w_dreq=0:
   - w_igrant=1 and w_maddr=5 the same cycle.
   - Next cycle r_ivalid=1 and w_irdata=RAM[5].
2. w_dreq=1, w_dwe=1, w_daddr=0x10, w_dwdata=0xDEADBEEF; next cycle load from 0x10:
   - w_mwe=1 in cycle 1 with no r_dvalid.
   - Cycle 2 load granted; cycle 3 r_dvalid=1 and w_drdata=0xDEADBEEF.
3. Both requests held continuously, STARVE_MAX=3:
   - Data granted 3 cycles with w_istall=1, then instruction granted in cycle 4.
   - Pattern repeats; r_forced=1 after cycle 4 (stats enabled).
4. Both requests for 2 cycles, then w_dreq=0:
   - Instruction granted cycle 3 and counter returns to 0.
   - A subsequent conflict again waits the full 3 cycles.
5. w_rst asserted the cycle after an instruction grant:
   - r_ivalid=0 the next cycle, grants=0 and w_mwe=0 while in reset.
   - Counters read 0 after release.
6. Without MEM_ARB_STATS_EN, run scenario 3 for 20 cycles:
   - Grant sequence identical to scenario 3.
   - r_conflicts=0 and r_forced=0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter for instruction-fetch and data ports (optional stats: MEM_ARB_STATS_EN)
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_ireq,
  input  logic [ADDR_W-1:0] w_iaddr,
  output logic              w_igrant,
  output logic              w_istall,
  output logic              r_ivalid,
  output logic [DATA_W-1:0] w_irdata,
  input  logic              w_dreq,
  input  logic              w_dwe,
  input  logic [ADDR_W-1:0] w_daddr,
  input  logic [DATA_W-1:0] w_dwdata,
  output logic              w_dgrant,
  output logic              r_dvalid,
  output logic [DATA_W-1:0] w_drdata,
  output logic [ADDR_W-1:0] w_maddr,
  output logic              w_mwe,
  output logic [DATA_W-1:0] w_mdin,
  input  logic [DATA_W-1:0] w_mdout,
  output logic [31:0]       r_conflicts,
  output logic [31:0]       r_forced
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic       ivalid_q, ivalid_d;
  logic       dvalid_q, dvalid_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       forced_grant;

  // Fixed data priority, except when the instruction side has waited STARVE_MAX cycles.
  always_comb begin
    w_igrant     = 1'b0;
    w_dgrant     = 1'b0;
    forced_grant = 1'b0;
    if (!w_rst) begin
      if (w_ireq && w_dreq) begin
        if (starve_cnt_q >= STARVE_LIM) begin
          w_igrant     = 1'b1;
          forced_grant = 1'b1;
        end else begin
          w_dgrant = 1'b1;
        end
      end else if (w_ireq) begin
        w_igrant = 1'b1;
      end else if (w_dreq) begin
        w_dgrant = 1'b1;
      end
    end
  end

  // RAM address/write mux follows the winner; idle cycles park the address at 0.
  always_comb begin
    w_maddr = '0;
    if (w_igrant) begin
      w_maddr = w_iaddr;
    end else if (w_dgrant) begin
      w_maddr = w_daddr;
    end
    w_mwe = w_dgrant & w_dwe;
  end

  assign w_mdin   = w_dwdata;
  assign w_irdata = w_mdout;
  assign w_drdata = w_mdout;
  assign w_istall = w_ireq & ~w_igrant;
  assign r_ivalid = ivalid_q;
  assign r_dvalid = dvalid_q;

  // Valid pulses track the one-cycle RAM latency; the starvation count saturates and clears on grant or withdrawn request.
  always_comb begin
    ivalid_d     = w_igrant;
    dvalid_d     = w_dgrant & ~w_dwe;
    starve_cnt_d = 4'd0;
    if (w_ireq && !w_igrant) begin
      starve_cnt_d = (starve_cnt_q >= STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 4'd1;
    end
  end

  // State registers; reset cancels any pending read return.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      ivalid_q     <= 1'b0;
      dvalid_q     <= 1'b0;
      starve_cnt_q <= 4'd0;
    end else begin
      ivalid_q     <= ivalid_d;
      dvalid_q     <= dvalid_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] conflicts_q, conflicts_d;
  logic [31:0] forced_q, forced_d;

  // Conflict and forced-grant counters, free-running with wrap.
  always_comb begin
    conflicts_d = conflicts_q + 32'(w_ireq & w_dreq);
    forced_d    = forced_q + 32'(forced_grant);
  end

  // Statistics registers.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      conflicts_q <= 32'd0;
      forced_q    <= 32'd0;
    end else begin
      conflicts_q <= conflicts_d;
      forced_q    <= forced_d;
    end
  end

  assign r_conflicts = conflicts_q;
  assign r_forced    = forced_q;
`else
  assign r_conflicts = 32'd0;
  assign r_forced    = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

`ifdef MEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        ireq;
  logic [11:0] iaddr;
  logic        igrant, istall, ivalid;
  logic [31:0] irdata;
  logic        dreq, dwe;
  logic [11:0] daddr;
  logic [31:0] dwdata;
  logic        dgrant, dvalid;
  logic [31:0] drdata;
  logic [11:0] maddr;
  logic        mwe;
  logic [31:0] mdin, mdout;
  logic [31:0] conflicts, forced;

  int checks = 0;
  int passed = 0;
  int exp_conf = 0;
  int exp_forced = 0;

  logic [31:0] ram [0:4095];

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(3)) dut (
    .w_clk(clk), .w_rst(rst),
    .w_ireq(ireq), .w_iaddr(iaddr), .w_igrant(igrant), .w_istall(istall),
    .r_ivalid(ivalid), .w_irdata(irdata),
    .w_dreq(dreq), .w_dwe(dwe), .w_daddr(daddr), .w_dwdata(dwdata),
    .w_dgrant(dgrant), .r_dvalid(dvalid), .w_drdata(drdata),
    .w_maddr(maddr), .w_mwe(mwe), .w_mdin(mdin), .w_mdout(mdout),
    .r_conflicts(conflicts), .r_forced(forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 4096; a++) ram[a] <= init_word(a);
    end else if (mwe) begin
      ram[maddr] <= mdin;
    end
    mdout <= ram[maddr];
  end

  task automatic test_reset;
    rst = 1'b1; ireq = 1'b1; iaddr = 12'd1; dreq = 1'b1; dwe = 1'b1; daddr = 12'd2; dwdata = 32'h1;
    @(negedge clk); #1;
    checks++; if ({igrant, dgrant, mwe} !== 3'b000) $display("FAIL reset_grants got %b exp 000", {igrant, dgrant, mwe}); else passed++;
    @(negedge clk); #1;
    checks++; if ({ivalid, dvalid} !== 2'b00) $display("FAIL reset_valids got %b exp 00", {ivalid, dvalid}); else passed++;
    rst = 1'b0; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
    @(negedge clk); #1;
    checks++; if (conflicts !== 32'd0 || forced !== 32'd0) $display("FAIL reset_stats got %0d/%0d exp 0/0", conflicts, forced); else passed++;
    checks++; if (istall !== 1'b0) $display("FAIL reset_istall got %b exp 0", istall); else passed++;
  endtask

  task automatic test_ifetch;
    @(negedge clk); ireq = 1'b1; iaddr = 12'd5; #1;
    checks++; if (igrant !== 1'b1 || maddr !== 12'd5 || istall !== 1'b0 || mwe !== 1'b0)
      $display("FAIL ifetch_grant got g=%b a=%0d s=%b we=%b exp 1/5/0/0", igrant, maddr, istall, mwe); else passed++;
    @(negedge clk); ireq = 1'b0; #1;
    checks++; if (ivalid !== 1'b1 || irdata !== 32'hA500_0005) $display("FAIL ifetch_data got v=%b d=%h exp 1/a5000005", ivalid, irdata); else passed++;
    @(negedge clk); #1;
    checks++; if (ivalid !== 1'b0) $display("FAIL ifetch_pulse got %b exp 0", ivalid); else passed++;
  endtask

  task automatic test_store_load;
    @(negedge clk); dreq = 1'b1; dwe = 1'b1; daddr = 12'h010; dwdata = 32'hDEADBEEF; #1;
    checks++; if (dgrant !== 1'b1 || mwe !== 1'b1 || maddr !== 12'h010 || mdin !== 32'hDEADBEEF)
      $display("FAIL store_drive got g=%b we=%b a=%h d=%h exp 1/1/010/deadbeef", dgrant, mwe, maddr, mdin); else passed++;
    @(negedge clk); dwe = 1'b0; #1;
    checks++; if (dvalid !== 1'b0 || dgrant !== 1'b1 || mwe !== 1'b0) $display("FAIL load_grant got v=%b g=%b we=%b exp 0/1/0", dvalid, dgrant, mwe); else passed++;
    @(negedge clk); dreq = 1'b0; #1;
    checks++; if (dvalid !== 1'b1 || drdata !== 32'hDEADBEEF) $display("FAIL raw_data got v=%b d=%h exp 1/deadbeef", dvalid, drdata); else passed++;
    checks++; if (ivalid !== 1'b0) $display("FAIL load_ivalid got %b exp 0", ivalid); else passed++;
  endtask

  task automatic test_starvation;
    logic exp_i, prev_d, prev_i;
    @(negedge clk); ireq = 1'b1; iaddr = 12'd7; dreq = 1'b1; dwe = 1'b0; daddr = 12'h020;
    for (int i = 0; i < 20; i++) begin
      #1;
      exp_i  = (i % 4 == 3);
      prev_i = (i > 0) && ((i - 1) % 4 == 3);
      prev_d = (i > 0) && !prev_i;
      checks++; if (igrant !== exp_i || dgrant !== !exp_i || istall !== !exp_i || maddr !== (exp_i ? 12'd7 : 12'h020))
        $display("FAIL starve_grant_c%0d got i=%b d=%b s=%b a=%h exp i=%b", i, igrant, dgrant, istall, maddr, exp_i); else passed++;
      checks++; if (ivalid !== prev_i || dvalid !== prev_d)
        $display("FAIL starve_valid_c%0d got iv=%b dv=%b exp %b/%b", i, ivalid, dvalid, prev_i, prev_d); else passed++;
      if (i == 4) begin
        checks++; if (forced !== (STATS ? 32'd1 : 32'd0)) $display("FAIL starve_forced1 got %0d exp %0d", forced, STATS ? 1 : 0); else passed++;
      end
      @(negedge clk);
    end
    ireq = 1'b0; dreq = 1'b0; #1;
    exp_conf += 20; exp_forced += 5;
    checks++; if (ivalid !== 1'b1 || irdata !== 32'hA500_0007) $display("FAIL starve_idata got v=%b d=%h exp 1/a5000007", ivalid, irdata); else passed++;
    checks++; if (conflicts !== (STATS ? 32'(exp_conf) : 32'd0) || forced !== (STATS ? 32'(exp_forced) : 32'd0))
      $display("FAIL starve_stats got %0d/%0d exp %0d/%0d", conflicts, forced, STATS ? exp_conf : 0, STATS ? exp_forced : 0); else passed++;
  endtask

  task automatic test_drop_dreq;
    logic exp_i;
    @(negedge clk); ireq = 1'b1; iaddr = 12'd9; dreq = 1'b1; dwe = 1'b0; daddr = 12'h021;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (dgrant !== 1'b1 || istall !== 1'b1) $display("FAIL drop_data_c%0d got d=%b s=%b exp 1/1", i, dgrant, istall); else passed++;
      @(negedge clk);
    end
    dreq = 1'b0; #1;
    checks++; if (igrant !== 1'b1 || maddr !== 12'd9) $display("FAIL drop_igrant got g=%b a=%0d exp 1/9", igrant, maddr); else passed++;
    @(negedge clk); dreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_i = (i == 3);
      checks++; if (igrant !== exp_i || dgrant !== !exp_i) $display("FAIL drop_rewait_c%0d got i=%b d=%b exp i=%b", i, igrant, dgrant, exp_i); else passed++;
      @(negedge clk);
    end
    ireq = 1'b0; dreq = 1'b0; #1;
    exp_conf += 6; exp_forced += 1;
    checks++; if (conflicts !== (STATS ? 32'(exp_conf) : 32'd0) || forced !== (STATS ? 32'(exp_forced) : 32'd0))
      $display("FAIL drop_stats got %0d/%0d exp %0d/%0d", conflicts, forced, STATS ? exp_conf : 0, STATS ? exp_forced : 0); else passed++;
  endtask

  task automatic test_reset_mid;
    logic exp_i;
    @(negedge clk); ireq = 1'b1; iaddr = 12'd5; #1;
    checks++; if (igrant !== 1'b1) $display("FAIL rmid_grant got %b exp 1", igrant); else passed++;
    @(negedge clk); rst = 1'b1; dreq = 1'b1; dwe = 1'b1; daddr = 12'd3; dwdata = 32'h55; #1;
    checks++; if (ivalid !== 1'b1) $display("FAIL rmid_prevalid got %b exp 1", ivalid); else passed++;
    checks++; if ({igrant, dgrant, mwe} !== 3'b000) $display("FAIL rmid_grants got %b exp 000", {igrant, dgrant, mwe}); else passed++;
    @(negedge clk); #1;
    checks++; if (ivalid !== 1'b0 || dvalid !== 1'b0) $display("FAIL rmid_cancel got %b/%b exp 0/0", ivalid, dvalid); else passed++;
    checks++; if ({igrant, dgrant, mwe} !== 3'b000) $display("FAIL rmid_grants2 got %b exp 000", {igrant, dgrant, mwe}); else passed++;
    @(negedge clk); rst = 1'b0; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; #1;
    checks++; if (conflicts !== 32'd0 || forced !== 32'd0) $display("FAIL rmid_stats got %0d/%0d exp 0/0", conflicts, forced); else passed++;
    @(negedge clk); ireq = 1'b1; dreq = 1'b1; daddr = 12'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_i = (i == 3);
      checks++; if (igrant !== exp_i || dgrant !== !exp_i) $display("FAIL rmid_rewait_c%0d got i=%b d=%b exp i=%b", i, igrant, dgrant, exp_i); else passed++;
      @(negedge clk);
    end
    ireq = 1'b0; dreq = 1'b0; #1;
    checks++; if (dvalid !== 1'b0 || ivalid !== 1'b1 || drdata !== 32'hA500_0005)
      $display("FAIL rmid_final got dv=%b iv=%b d=%h exp 0/1/a5000005", dvalid, ivalid, drdata); else passed++;
  endtask

  initial begin
    rst = 1'b1; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwe = 1'b0; daddr = '0; dwdata = '0;
    test_reset();
    test_ifetch();
    test_store_load();
    test_starvation();
    test_drop_dreq();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
